cache_refill_ctrl: RTL and testbench

//  Miss/refill sequencer for the 2-way data cache, in the MEM stage beside the control unit.
//  - Load hit: updates LRU with no stall.
//  - Load miss: stalls the pipeline, burst-reads one block from main memory into the

---
 rtl/cache_refill_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss/refill sequencer for a 2-way write-through data cache
// Loads that miss burst-fill the victim way; stores go straight to memory.
module cache_refill_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8,
    parameter int BLOCK_WORDS   = 4,
    localparam int IW           = $clog2(SETS),
    localparam int OW           = $clog2(BLOCK_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic                     hit_way0,
    input  logic                     hit_way1,
    input  logic                     lru_way,
    output logic                     stall,
    output logic                     mem_rd_req,
    output logic                     mem_wr_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     fill_we,
    output logic                     fill_way,
    output logic [IW-1:0]            fill_index,
    output logic [OW-1:0]            fill_offset,
    output logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     tag_valid_we,
    output logic                     lru_update,
    output logic                     lru_way_used
);

    localparam logic [OW-1:0] LAST_WORD = OW'(BLOCK_WORDS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_FINISH,
        S_WRITE
    } state_e;

    state_e                   state_q, state_d;
    logic [OW-1:0]            cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     victim_q, victim_d;

    logic hit;
    logic hit_way;
    logic [IW-1:0] addr_index;

    assign hit        = hit_way0 | hit_way1;
    // way0 takes priority when both tag compares fire
    assign hit_way    = !hit_way0;
    // set index sits directly above the word offset within the block
    assign addr_index = addr_q[OW+2 +: IW];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        stall        = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_we      = 1'b0;
        fill_way     = 1'b0;
        fill_index   = '0;
        fill_offset  = '0;
        fill_data    = '0;
        tag_valid_we = 1'b0;
        lru_update   = 1'b0;
        lru_way_used = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        stall        = 1'b1;
                        addr_d       = req_addr;
                        wdata_d      = req_wdata;
                        lru_update   = hit;
                        lru_way_used = hit & hit_way;
                        state_d      = S_WRITE;
                    end else if (hit) begin
                        lru_update   = 1'b1;
                        lru_way_used = hit_way;
                    end else begin
                        stall    = 1'b1;
                        addr_d   = req_addr;
                        victim_d = lru_way;
                        cnt_d    = '0;
                        state_d  = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                stall       = 1'b1;
                mem_rd_req  = 1'b1;
                mem_addr    = {addr_q[ADDRESS_WIDTH-1:OW+2], cnt_q, 2'b00};
                fill_way    = victim_q;
                fill_index  = addr_index;
                fill_offset = cnt_q;
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    fill_data = mem_rdata;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                stall        = 1'b1;
                tag_valid_we = 1'b1;
                fill_way     = victim_q;
                fill_index   = addr_index;
                lru_update   = 1'b1;
                lru_way_used = victim_q;
                state_d      = S_IDLE;
            end

            S_WRITE: begin
                mem_wr_req = 1'b1;
                mem_addr   = addr_q & WORD_MASK;
                mem_wdata  = wdata_q;
                // releasing stall on the ack cycle lets the pipeline advance on that edge
                stall      = !mem_ack;
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int BW   = 4;
    localparam int SETS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        hit_way0 = 1'b0;
    logic        hit_way1 = 1'b0;
    logic        lru_way = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall, mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wdata, fill_data;
    logic        fill_we, fill_way, tag_valid_we, lru_update, lru_way_used;
    logic [2:0]  fill_index;
    logic [1:0]  fill_offset;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .hit_way0(hit_way0),
        .hit_way1(hit_way1), .lru_way(lru_way), .stall(stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
        .fill_offset(fill_offset), .fill_data(fill_data), .tag_valid_we(tag_valid_we),
        .lru_update(lru_update), .lru_way_used(lru_way_used)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 0);
        chk({tag, ".mem_rd_req"}, 32'(mem_rd_req), 0);
        chk({tag, ".mem_wr_req"}, 32'(mem_wr_req), 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".fill_we"}, 32'(fill_we), 0);
        chk({tag, ".fill_way"}, 32'(fill_way), 0);
        chk({tag, ".fill_index"}, 32'(fill_index), 0);
        chk({tag, ".fill_offset"}, 32'(fill_offset), 0);
        chk({tag, ".fill_data"}, fill_data, 0);
        chk({tag, ".tag_valid_we"}, 32'(tag_valid_we), 0);
        chk({tag, ".lru_update"}, 32'(lru_update), 0);
        chk({tag, ".lru_way_used"}, 32'(lru_way_used), 0);
    endtask

    task automatic run_load_hit(input logic [31:0] addr, input logic h0, input logic h1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        hit_way0 = h0; hit_way1 = h1; mem_ack = 1'b0;
        settle();
        chk("hit.stall", 32'(stall), 0);
        chk("hit.lru_update", 32'(lru_update), 1);
        chk("hit.lru_way_used", 32'(lru_way_used), h0 ? 0 : 1);
        chk("hit.mem_rd_req", 32'(mem_rd_req), 0);
        chk("hit.mem_wr_req", 32'(mem_wr_req), 0);
        adv();
        req_valid = 1'b0; hit_way0 = 1'b0; hit_way1 = 1'b0;
    endtask

    // gap_mode < 0 draws a random 0..3 cycle wait before each word's ack
    task automatic run_load_miss(input logic [31:0] addr, input logic v, input int gap_mode);
        int gaps[BW];
        int gap_sum;
        int stalls;
        int idx;
        logic [31:0] base;
        logic [31:0] rd;
        base = addr & ~32'(BW * 4 - 1);
        idx = int'((addr / (BW * 4)) % SETS);
        gap_sum = 0;
        for (int k = 0; k < BW; k++) begin
            gaps[k] = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
            gap_sum += gaps[k];
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        hit_way0 = 1'b0; hit_way1 = 1'b0; lru_way = v; mem_ack = 1'b0;
        settle();
        chk("miss.idle.stall", 32'(stall), 1);
        chk("miss.idle.mem_rd_req", 32'(mem_rd_req), 0);
        chk("miss.idle.lru_update", 32'(lru_update), 0);
        stalls = int'(stall);
        adv();
        for (int k = 0; k < BW; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                lru_way = 1'($urandom_range(0, 1));
                req_addr = $urandom;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                settle();
                chk("miss.wait.mem_rd_req", 32'(mem_rd_req), 1);
                chk("miss.wait.mem_addr", mem_addr, base + 32'(4 * k));
                chk("miss.wait.fill_we", 32'(fill_we), 0);
                stalls += int'(stall);
                adv();
            end
            rd = $urandom;
            mem_ack = 1'b1;
            mem_rdata = rd;
            settle();
            chk("miss.ack.fill_we", 32'(fill_we), 1);
            chk("miss.ack.mem_addr", mem_addr, base + 32'(4 * k));
            chk("miss.ack.fill_offset", 32'(fill_offset), 32'(k));
            chk("miss.ack.fill_way", 32'(fill_way), 32'(v));
            chk("miss.ack.fill_index", 32'(fill_index), 32'(idx));
            chk("miss.ack.fill_data", fill_data, rd);
            chk("miss.ack.tag_valid_we", 32'(tag_valid_we), 0);
            stalls += int'(stall);
            adv();
        end
        req_addr = addr; lru_way = v;
        mem_ack = 1'b1;
        settle();
        chk("miss.fin.tag_valid_we", 32'(tag_valid_we), 1);
        chk("miss.fin.fill_way", 32'(fill_way), 32'(v));
        chk("miss.fin.fill_index", 32'(fill_index), 32'(idx));
        chk("miss.fin.lru_update", 32'(lru_update), 1);
        chk("miss.fin.lru_way_used", 32'(lru_way_used), 32'(v));
        chk("miss.fin.fill_we", 32'(fill_we), 0);
        chk("miss.fin.mem_rd_req", 32'(mem_rd_req), 0);
        stalls += int'(stall);
        adv();
        mem_ack = 1'b0;
        hit_way0 = (v == 1'b0); hit_way1 = (v == 1'b1);
        settle();
        chk("miss.rehit.stall", 32'(stall), 0);
        chk("miss.rehit.lru_update", 32'(lru_update), 1);
        chk("miss.rehit.lru_way_used", 32'(lru_way_used), 32'(v));
        chk("miss.rehit.tag_valid_we", 32'(tag_valid_we), 0);
        stalls += int'(stall);
        chk("miss.stall_cycles", 32'(stalls), 32'(gap_sum + BW + 2));
        adv();
        req_valid = 1'b0; hit_way0 = 1'b0; hit_way1 = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic h0, input logic h1, input int gap);
        int wr_cycles;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
        hit_way0 = h0; hit_way1 = h1; mem_ack = 1'b0;
        settle();
        chk("st.idle.stall", 32'(stall), 1);
        chk("st.idle.lru_update", 32'(lru_update), 32'(h0 | h1));
        if (h0 | h1) chk("st.idle.lru_way_used", 32'(lru_way_used), h0 ? 0 : 1);
        chk("st.idle.mem_wr_req", 32'(mem_wr_req), 0);
        adv();
        hit_way0 = 1'b0; hit_way1 = 1'b0;
        wr_cycles = 0;
        for (int g = 0; g < gap; g++) begin
            req_addr = $urandom; req_wdata = $urandom;
            settle();
            chk("st.wait.stall", 32'(stall), 1);
            chk("st.wait.mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("st.wait.mem_wdata", mem_wdata, data);
            wr_cycles += int'(mem_wr_req);
            adv();
        end
        mem_ack = 1'b1;
        settle();
        chk("st.ack.stall", 32'(stall), 0);
        chk("st.ack.mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("st.ack.mem_wdata", mem_wdata, data);
        wr_cycles += int'(mem_wr_req);
        chk("st.wr_cycles", 32'(wr_cycles), 32'(gap + 1));
        adv();
        req_valid = 1'b0; mem_ack = 1'b0;
        settle();
        chk("st.after.mem_wr_req", 32'(mem_wr_req), 0);
        chk("st.after.stall", 32'(stall), 0);
        adv();
    endtask

    initial begin
        adv();
        adv();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        settle();
        chk_all_zero("reset");
        adv();
        mem_ack = 1'b0;

        run_load_hit(32'h40, 1'b0, 1'b1);
        run_load_hit(32'h44, 1'b1, 1'b1);
        run_load_miss(32'h124, 1'b1, 0);
        run_load_miss(32'h3A8, 1'b0, 3);
        run_store(32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
        run_store(32'h1237, 32'h0BAD_F00D, 1'b0, 1'b1, 0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; lru_way = 1'b1;
        settle();
        adv();
        mem_ack = 1'b1;
        settle();
        adv();
        rst_n = 1'b0;
        settle();
        chk("rst.mid.fill_offset", 32'(fill_offset), 1);
        adv();
        rst_n = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
        settle();
        chk_all_zero("rst.after");
        adv();
        settle();
        chk_all_zero("rst.after2");
        adv();
        run_load_miss(32'h30C, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: run_load_hit($urandom, 1'($urandom_range(0, 1)), 1'b1);
                1: run_load_miss($urandom, 1'($urandom_range(0, 1)), -1);
                default: run_store($urandom, $urandom, 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
